// File: rtl/zoom_out_average.sv
// Zoom-out pass: clears the frame buffer, then writes a 2x2-averaged half-size copy of
// the source image into a window of that buffer, one tap per ROM read round trip.
module zoom_out_average #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int DST_X0 = 80,
    parameter int DST_Y0 = 60,
    parameter int RD_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rom_data_in,
    output logic [16:0] rom_addr,
    output logic [18:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT,
        ACC,
        WRITE,
        FINISH
    } state_t;

    localparam int          OUT_W        = SRC_W / 2;
    localparam int          OUT_H        = SRC_H / 2;
    localparam logic [18:0] FRAME_LAST   = 19'(SRC_W * SRC_H - 1);
    localparam logic [18:0] DST_BASE0    = 19'(DST_Y0 * SRC_W + DST_X0);
    localparam logic [18:0] SRC_ROW_STEP = 19'(SRC_W + 2);
    localparam logic [18:0] DST_ROW_STEP = 19'(SRC_W - OUT_W + 1);
    localparam logic [15:0] DX_LAST      = 16'(OUT_W - 1);
    localparam logic [15:0] DY_LAST      = 16'(OUT_H - 1);
    localparam logic [7:0]  WAIT_LAST    = 8'(RD_LAT - 2);

    state_t      state;
    logic [18:0] src_base;
    logic [18:0] dst_base;
    logic [15:0] dx;
    logic [15:0] dy;
    logic [1:0]  tap;
    logic [7:0]  wait_cnt;
    logic [4:0]  r_sum;
    logic [4:0]  g_sum;
    logic [3:0]  b_sum;

    logic [4:0]  r_acc;
    logic [4:0]  g_acc;
    logic [3:0]  b_acc;
    logic [1:0]  tap_nxt;
    logic        row_end;
    logic        last_pixel;
    logic [18:0] src_next;
    logic [18:0] dst_next;

    // Offset of each tap from the top-left source pixel of the 2x2 block.
    function automatic logic [18:0] tap_offset(input logic [1:0] t);
        case (t)
            2'd0:    return 19'd0;
            2'd1:    return 19'd1;
            2'd2:    return 19'(SRC_W);
            default: return 19'(SRC_W + 1);
        endcase
    endfunction

    // Truncating divide-by-four of each channel sum, repacked as RGB332.
    function automatic logic [7:0] avg_pixel(input logic [4:0] r,
                                             input logic [4:0] g,
                                             input logic [3:0] b);
        return {3'(r >> 2), 3'(g >> 2), 2'(b >> 2)};
    endfunction

    assign r_acc      = r_sum + {2'b00, rom_data_in[7:5]};
    assign g_acc      = g_sum + {2'b00, rom_data_in[4:2]};
    assign b_acc      = b_sum + {2'b00, rom_data_in[1:0]};
    assign tap_nxt    = tap + 2'd1;
    assign row_end    = (dx == DX_LAST);
    assign last_pixel = row_end && (dy == DY_LAST);
    assign src_next   = row_end ? src_base + SRC_ROW_STEP : src_base + 19'd2;
    assign dst_next   = row_end ? dst_base + DST_ROW_STEP : dst_base + 19'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rom_addr <= '0;
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            src_base <= '0;
            dst_base <= '0;
            dx       <= '0;
            dy       <= '0;
            tap      <= '0;
            wait_cnt <= '0;
            r_sum    <= '0;
            g_sum    <= '0;
            b_sum    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        ram_addr <= '0;
                        ram_data <= '0;
                        ram_wren <= 1'b1;
                        src_base <= '0;
                        dst_base <= DST_BASE0;
                        dx       <= '0;
                        dy       <= '0;
                        tap      <= '0;
                        r_sum    <= '0;
                        g_sum    <= '0;
                        b_sum    <= '0;
                    end
                end
                // ram_addr doubles as the clear counter; data stays 8'h00 throughout.
                CLEAR: begin
                    if (ram_addr == FRAME_LAST) begin
                        ram_wren <= 1'b0;
                        rom_addr <= 17'(src_base);
                        state    <= ISSUE;
                    end else begin
                        ram_addr <= ram_addr + 19'd1;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= (RD_LAT > 1) ? WAIT : ACC;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ACC;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                // Final tap goes straight into the write so the sum never needs a spare cycle.
                ACC: begin
                    r_sum <= r_acc;
                    g_sum <= g_acc;
                    b_sum <= b_acc;
                    if (tap == 2'd3) begin
                        ram_addr <= dst_base;
                        ram_data <= avg_pixel(r_acc, g_acc, b_acc);
                        ram_wren <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        tap      <= tap_nxt;
                        rom_addr <= 17'(src_base + tap_offset(tap_nxt));
                        state    <= ISSUE;
                    end
                end
                WRITE: begin
                    ram_wren <= 1'b0;
                    r_sum    <= '0;
                    g_sum    <= '0;
                    b_sum    <= '0;
                    tap      <= '0;
                    if (last_pixel) begin
                        state <= FINISH;
                    end else begin
                        dx       <= row_end ? 16'd0 : dx + 16'd1;
                        dy       <= row_end ? dy + 16'd1 : dy;
                        src_base <= src_next;
                        dst_base <= dst_next;
                        rom_addr <= 17'(src_next);
                        state    <= ISSUE;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zoom_out_average.sv
// Bench for zoom_out_average at a reduced frame size; a queue of expected frame-buffer
// writes is computed directly from the source image and checked on every write strobe.
module tb_zoom_out_average;

    localparam int SRC_W  = 16;
    localparam int SRC_H  = 8;
    localparam int DST_X0 = 4;
    localparam int DST_Y0 = 2;
    localparam int RD_LAT = 2;
    localparam int NPIX   = SRC_W * SRC_H;
    localparam int OUT_W  = SRC_W / 2;
    localparam int OUT_H  = SRC_H / 2;
    // clear + per-pixel cost + one FINISH cycle between the last write and done
    localparam int PASS_CYC = NPIX + OUT_W * OUT_H * (4 * (RD_LAT + 1) + 1) + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_data_in;
    logic [16:0] rom_addr;
    logic [18:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic        busy;
    logic        done;

    zoom_out_average #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H),
        .DST_X0(DST_X0),
        .DST_Y0(DST_Y0),
        .RD_LAT(RD_LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rom_data_in(rom_data_in),
        .rom_addr   (rom_addr),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t        exp_q[$];
    int         rom_hist[$];
    logic [7:0] mem[NPIX];
    logic [7:0] fb_dut[NPIX];
    logic [7:0] rom_pipe[RD_LAT];
    int         total = 0;
    int         bad = 0;
    int         last_wr_addr = -1;
    int         prev_rom = 0;

    // Source ROM: RD_LAT register stages between address and data.
    always @(posedge clock) begin
        rom_pipe[0] <= (int'(rom_addr) < NPIX) ? mem[int'(rom_addr)] : 8'h00;
        for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data_in = rom_pipe[RD_LAT-1];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected write stream: full clear, then every averaged pixel in raster order.
    task automatic build_expect();
        exp_q.delete();
        for (int a = 0; a < NPIX; a++) exp_q.push_back('{a, 0});
        for (int dy = 0; dy < OUT_H; dy++) begin
            for (int dx = 0; dx < OUT_W; dx++) begin
                int r, g, b;
                r = 0; g = 0; b = 0;
                for (int t = 0; t < 4; t++) begin
                    logic [7:0] px;
                    px = mem[(2*dy + t/2) * SRC_W + 2*dx + t%2];
                    r += int'(px[7:5]);
                    g += int'(px[4:2]);
                    b += int'(px[1:0]);
                end
                exp_q.push_back('{(DST_Y0 + dy) * SRC_W + DST_X0 + dx,
                                  (r / 4) * 32 + (g / 4) * 4 + (b / 4)});
            end
        end
    endtask

    // Compare process: every strobe must match the head of the expected stream.
    always @(negedge clock) begin
        wr_t e;
        if (reset) begin
            if (ram_wren) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", int'(ram_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(ram_addr), e.addr);
                    check("wr_data", int'(ram_data), e.data);
                end
                if (int'(ram_addr) < NPIX) fb_dut[int'(ram_addr)] = ram_data;
                last_wr_addr = int'(ram_addr);
            end
            if (int'(rom_addr) != prev_rom) rom_hist.push_back(int'(rom_addr));
            prev_rom = int'(rom_addr);
        end
    end

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        check("done_cleared_on_start", int'(done), 0);
        check("busy_set_on_start", int'(busy), 1);
    endtask

    task automatic run_pass(input int busy_pokes, output int cycles);
        rom_hist.delete();
        pulse_start();
        cycles = 0;
        while (!done && cycles < PASS_CYC + 200) begin
            @(posedge clock); cycles++; #1;
            start = (busy_pokes != 0) && (cycles == 50 || cycles == 300);
        end
        start = 1'b0;
        check("pass_cycles", cycles, PASS_CYC);
        check("done_at_end", int'(done), 1);
        check("busy_at_end", int'(busy), 0);
        check("expected_writes_left", exp_q.size(), 0);
        repeat (5) @(posedge clock);
        #1 check("done_held", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < NPIX; i++) fb_dut[i] = 8'h5A;

        // Reset values while reset is held low.
        #1;
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_data", int'(ram_data), 0);
        check("rst_ram_wren", int'(ram_wren), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;

        // Pass A: all-white source, with starts poked while busy.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'hFF;
        build_expect();
        run_pass(1, cyc);
        check("A_win_first", int'(fb_dut[DST_Y0*SRC_W + DST_X0]), 255);
        check("A_left_of_win", int'(fb_dut[DST_Y0*SRC_W + DST_X0 - 1]), 0);
        check("A_win_last", int'(fb_dut[91]), 255);
        check("A_right_of_win", int'(fb_dut[92]), 0);
        check("A_frame_origin", int'(fb_dut[0]), 0);

        // Pass B: random source with a pinned red/black block at (0,0).
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hE0; mem[1] = 8'h00; mem[SRC_W] = 8'hE0; mem[SRC_W+1] = 8'h00;
        build_expect();
        run_pass(0, cyc);
        check("B_block_avg", int'(fb_dut[36]), 8'h60);
        check("B_last_write_addr", last_wr_addr, 91);
        check("B_rom_hist_len_ok", int'(rom_hist.size() >= 4), 1);
        if (rom_hist.size() >= 4) begin
            check("B_last_tap0", rom_hist[rom_hist.size()-4], 110);
            check("B_last_tap1", rom_hist[rom_hist.size()-3], 111);
            check("B_last_tap2", rom_hist[rom_hist.size()-2], 126);
            check("B_last_tap3", rom_hist[rom_hist.size()-1], 127);
        end

        // Pass C: reset pulled low during the ACC of pixel 5, tap 1.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        build_expect();
        pulse_start();
        repeat (NPIX + 5 * 13 + 3 + 2) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("midrst_rom_addr", int'(rom_addr), 0);
        check("midrst_ram_addr", int'(ram_addr), 0);
        check("midrst_ram_data", int'(ram_data), 0);
        check("midrst_ram_wren", int'(ram_wren), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        repeat (80) @(posedge clock);
        #1;
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_done", int'(done), 0);
        check("post_rst_wren", int'(ram_wren), 0);

        // Pass D: fresh random pass after the interrupted one.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        build_expect();
        run_pass(0, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zoom_out_average.md
ZOOM_OUT_AVERAGE -- requirements
Module: zoom_out_average

Interface
REQ-001 SHALL have parameter SRC_W, default 320, source image width in pixels.
REQ-002 SHALL have parameter SRC_H, default 240, source image height in pixels.
REQ-003 SHALL have parameter DST_X0, default 80, x offset of the reduced image inside the SRC_W x SRC_H frame buffer.
REQ-004 SHALL have parameter DST_Y0, default 60, y offset of the reduced image inside the frame buffer.
REQ-005 SHALL have parameter RD_LAT, default 2, cycles from rom_addr presentation to valid rom_data_in.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: one-cycle request to begin a zoom-out pass.
REQ-009 SHALL have port rom_data_in, input, 8 bits: RGB332 source pixel (R[7:5], G[4:2], B[1:0]).
REQ-010 SHALL have port rom_addr, output, 17 bits: source read address.
REQ-011 SHALL have port ram_addr, output, 19 bits: frame-buffer write address.
REQ-012 SHALL have port ram_data, output, 8 bits: frame-buffer write data.
REQ-013 SHALL have port ram_wren, output, 1 bit: frame-buffer write strobe.
REQ-014 SHALL have port busy, output, 1 bit: high while a pass is in progress.
REQ-015 SHALL have port done, output, 1 bit: high after a pass completes.

Function
REQ-016 SHALL implement states IDLE, CLEAR, ISSUE, WAIT, ACC, WRITE, FINISH.
REQ-017 IDLE: on start=1, SHALL clear done, set busy and enter CLEAR; start in any other state SHALL be ignored.
REQ-018 CLEAR: SHALL write 8'h00 to ram_addr 0..SRC_W*SRC_H-1, one address per cycle, with ram_wren=1, then enter ISSUE.
REQ-019 Reduced image SHALL be (SRC_W/2) x (SRC_H/2); output pixel (dx,dy) SHALL average source pixels (2dx,2dy), (2dx+1,2dy), (2dx,2dy+1), (2dx+1,2dy+1), read in that order.
REQ-020 ISSUE: SHALL drive rom_addr = sy*SRC_W + sx for the current tap and enter WAIT; rom_addr SHALL hold until the tap is sampled.
REQ-021 WAIT: SHALL count RD_LAT-1 cycles, then enter ACC; ACC SHALL sample rom_data_in exactly RD_LAT cycles after ISSUE.
REQ-022 ACC: SHALL accumulate R, G and B separately into 5-, 5- and 4-bit sums; after the 4th tap SHALL enter WRITE, otherwise ISSUE for the next tap.
REQ-023 WRITE: SHALL drive ram_data = {Rsum>>2, Gsum>>2, Bsum>>2} (truncating), ram_addr = (DST_Y0+dy)*SRC_W + DST_X0+dx and ram_wren=1 for one cycle, then clear the sums.
REQ-024 Output raster SHALL advance dx first and wrap dx to 0 with dy+1 at dx=SRC_W/2-1; after (SRC_W/2-1, SRC_H/2-1) SHALL enter FINISH.
REQ-025 Cycles per output pixel SHALL be 4*(RD_LAT+1)+1 (13 at default); ram_wren SHALL be 0 in all states other than CLEAR and WRITE.
REQ-026 FINISH: SHALL clear busy, set done and return to IDLE; done SHALL stay high until the next accepted start.
REQ-027 All address arithmetic SHALL be unsigned with no overflow at defaults (max rom_addr 76799, max ram_addr 76799).

Reset
REQ-028 reset=0 SHALL immediately force state IDLE and rom_addr=0, ram_addr=0, ram_data=0, ram_wren=0, busy=0, done=0, and clear all counters and sums, including in the middle of a pass.
REQ-029 After reset is released mid-pass, the block SHALL remain in IDLE with no further writes until a new start.

Verification
REQ-030 ROM all 8'hFF, start -> addresses 0..76799 written 8'h00, then the 160x120 window at (80,60) written 8'hFF; done=1, busy=0.
REQ-031 2x2 block taps 8'hE0,8'h00,8'hE0,8'h00 -> written pixel 8'h60 (red 14>>2=3).
REQ-032 Last output pixel -> rom_addr sequence 76478, 76479, 76798, 76799, followed by a write to ram_addr 57519.
REQ-033 Cycle count from start to done = 76800 + 19200*13 (+FSM overhead fixed and documented by the bench); a start pulsed while busy=1 -> no effect.
REQ-034 reset=0 asserted mid-ACC -> all outputs at reset values in the same cycle; no ram_wren until the next start.
